// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master round-robin bus arbiter with registered grant,
//               latched address and one-hot slave decode. Define
//               ARB_TIMEOUT_EN to add the transfer timeout and bus_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] m_addr,
    input  logic         slave_ack,
    output logic [3:0]   grant,
    output logic [31:0]  bus_addr,
    output logic [3:0]   slave_en,
    output logic         busy,
    output logic         bus_err
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_XFER = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [0:0]  r_state,      w_state_nxt;
    logic [1:0]  r_last_owner, w_last_owner_nxt;
    logic [1:0]  r_owner,      w_owner_nxt;
    logic [3:0]  r_grant,      w_grant_nxt;
    logic [31:0] r_bus_addr,   w_bus_addr_nxt;
    logic [3:0]  r_slave_en,   w_slave_en_nxt;
    logic        r_busy,       w_busy_nxt;
    logic [1:0]  w_winner;
    logic [31:0] w_win_addr;
    logic        w_done;
    logic        w_timeout;

    // Walk offsets 4..1 so the nearest requester after last_owner wins last.
    always_comb begin
        w_winner = r_last_owner + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            if (req[r_last_owner + 2'(i)]) begin
                w_winner = r_last_owner + 2'(i);
            end
        end
    end

    assign w_win_addr = m_addr[{w_winner, 5'd0} +: 32];
    assign w_done     = slave_ack | ~req[r_owner];

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bus_err;

    // Counter holds the number of XFER edges already survived without ack.
    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= (r_state == c_ST_XFER) && !w_done && w_timeout;
            if ((r_state == c_ST_XFER) && !w_done && !w_timeout) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_owner_nxt      = r_owner;
        w_grant_nxt      = r_grant;
        w_bus_addr_nxt   = r_bus_addr;
        w_slave_en_nxt   = r_slave_en;
        w_busy_nxt       = r_busy;
        case (r_state)
            c_ST_IDLE: begin
                if (|req) begin
                    w_state_nxt    = c_ST_XFER;
                    w_owner_nxt    = w_winner;
                    w_grant_nxt    = 4'b0001 << w_winner;
                    w_bus_addr_nxt = w_win_addr;
                    w_slave_en_nxt = 4'b0001 << w_win_addr[31:30];
                    w_busy_nxt     = 1'b1;
                end
            end
            c_ST_XFER: begin
                // Ack, owner withdrawal and timeout all release the bus alike.
                if (w_done || w_timeout) begin
                    w_state_nxt      = c_ST_IDLE;
                    w_last_owner_nxt = r_owner;
                    w_grant_nxt      = 4'b0000;
                    w_slave_en_nxt   = 4'b0000;
                    w_busy_nxt       = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_last_owner <= 2'd3;
            r_owner      <= 2'd0;
            r_grant      <= 4'b0000;
            r_bus_addr   <= 32'd0;
            r_slave_en   <= 4'b0000;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_owner      <= w_owner_nxt;
            r_grant      <= w_grant_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_slave_en   <= w_slave_en_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign grant    = r_grant;
    assign bus_addr = r_bus_addr;
    assign slave_en = r_slave_en;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Scoreboard bench for bus_arbiter: directed scenarios plus
//               randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int c_TO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] m_addr;
    logic         slave_ack;
    logic [3:0]   grant;
    logic [31:0]  bus_addr;
    logic [3:0]   slave_en;
    logic         busy;
    logic         bus_err;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .m_addr    (m_addr),
        .slave_ack (slave_ack),
        .grant     (grant),
        .bus_addr  (bus_addr),
        .slave_en  (slave_en),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: owner == -1 means the bus is free.
    typedef struct {
        logic [3:0]  g;
        logic [31:0] a;
        logic [3:0]  s;
        logic        b;
        logic        e;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mdl_e;
    exp_t        mon_e;
    int          m_owner = -1;
    int          m_last  = 3;
    int          m_cnt   = 0;
    int          m_w;
    bit          m_found;
    bit          m_err;
    logic [31:0] m_lat = 32'd0;

    always @(posedge clk) begin
        m_err = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 3;
            m_cnt   = 0;
            m_lat   = 32'd0;
        end else if (m_owner < 0) begin
            m_found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                m_w = (m_last + k) % 4;
                if (!m_found && req[m_w]) begin
                    m_found = 1'b1;
                    m_owner = m_w;
                    m_lat   = m_addr[32*m_w +: 32];
                    m_cnt   = 0;
                end
            end
        end else begin
            if (slave_ack || !req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                m_cnt++;
                if (m_cnt >= c_TO) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_err   = 1'b1;
                end
            end
`endif
        end
        mdl_e.g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        mdl_e.s = (m_owner < 0) ? 4'b0000 : 4'(1 << m_lat[31:30]);
        mdl_e.b = (m_owner >= 0);
        mdl_e.a = m_lat;
        mdl_e.e = m_err;
        sb_q.push_back(mdl_e);
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sb_grant",    32'(grant),    32'(mon_e.g));
            chk("sb_bus_addr", bus_addr,      mon_e.a);
            chk("sb_slave_en", 32'(slave_en), 32'(mon_e.s));
            chk("sb_busy",     32'(busy),     32'(mon_e.b));
            chk("sb_bus_err",  32'(bus_err),  32'(mon_e.e));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        logic [3:0] r;
        rst_n     = 1'b0;
        req       = 4'b0000;
        m_addr    = '0;
        slave_ack = 1'b0;
        cyc();
        cyc();
        chk("reset_grant",    32'(grant),    32'h0);
        chk("reset_slave_en", 32'(slave_en), 32'h0);
        chk("reset_bus_addr", bus_addr,      32'h0);
        chk("reset_busy",     32'(busy),     32'h0);
        rst_n = 1'b1;
        cyc();

        // Single transfer from master 0 to slave 1.
        req           = 4'b0001;
        m_addr[31:0]  = 32'h4000_0010;
        cyc();
        chk("m0_grant",    32'(grant),    32'h1);
        chk("m0_bus_addr", bus_addr,      32'h4000_0010);
        chk("m0_slave_en", 32'(slave_en), 32'h2);
        chk("m0_busy",     32'(busy),     32'h1);
        slave_ack = 1'b1;
        cyc();
        chk("m0_ack_grant",    32'(grant),    32'h0);
        chk("m0_ack_slave_en", 32'(slave_en), 32'h0);
        chk("m0_ack_busy",     32'(busy),     32'h0);
        req       = 4'b0000;
        slave_ack = 1'b0;
        cyc();

        // Master 2 address change during XFER must not disturb the bus.
        req           = 4'b0100;
        m_addr[95:64] = 32'hC000_0000;
        cyc();
        chk("m2_grant",    32'(grant),    32'h4);
        chk("m2_slave_en", 32'(slave_en), 32'h8);
        m_addr[95:64] = 32'h0000_0000;
        cyc();
        cyc();
        chk("m2_hold_addr",     bus_addr,      32'hC000_0000);
        chk("m2_hold_slave_en", 32'(slave_en), 32'h8);
        slave_ack = 1'b1;
        cyc();
        chk("m2_ack_grant", 32'(grant), 32'h0);
        req       = 4'b0000;
        slave_ack = 1'b0;
        cyc();

        // Round-robin rotation with all masters requesting.
        rst_n = 1'b0;
        cyc();
        rst_n     = 1'b1;
        req       = 4'b1111;
        slave_ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk($sformatf("rr_seq%0d", k), 32'(grant), 32'(rr_seq[k]));
        end
        req       = 4'b0000;
        slave_ack = 1'b0;
        cyc();
        chk("drop_abort_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a master 3 transfer.
        req = 4'b1000;
        cyc();
        chk("m3_grant", 32'(grant), 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_grant",    32'(grant),    32'h0);
        chk("async_slave_en", 32'(slave_en), 32'h0);
        chk("async_bus_addr", bus_addr,      32'h0);
        chk("async_busy",     32'(busy),     32'h0);
        chk("async_bus_err",  32'(bus_err),  32'h0);
        req = 4'b1001;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_grant", 32'(grant), 32'h1);

        // Randomized traffic, checked solely by the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 11) == 0) r[i] = 1'b0;
                end else if (r[i]) begin
                    if ($urandom_range(0, 7) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            req       = r;
            slave_ack = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) m_addr[32*i +: 32] = $urandom;
            end
            rst_n = ($urandom_range(0, 399) != 0);
            cyc();
        end

        rst_n     = 1'b1;
        req       = 4'b0000;
        slave_ack = 1'b0;
        cyc();
        cyc();
        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
